// File: rtl/scale_capture_buffer_if.sv
// rtl/scale_capture_buffer_if.sv - sample stream and frame read port of the capture buffer.
// The acquisition side drives samples and read addresses; the buffer returns read data.
interface scale_capture_buffer_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] data_input;
  logic              sample_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output data_input,
    output sample_valid,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  data_input,
    input  sample_valid,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/scale_capture_buffer.sv
// rtl/scale_capture_buffer.sv - single-channel frame capture with gain and decimation.
// Gain and decimation are latched at arm time; the frame is read back through a registered port.
module scale_capture_buffer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  scale_capture_buffer_if.slave   bus,
  input  logic [1:0]              scale,
  input  logic [1:0]              decim,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W:0]         wr_count
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic [1:0]        scale_q;
  logic [1:0]        decim_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W:0]   wr_count_q;
  logic [2:0]        dec_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]        dec_max;
  logic              keep;
  logic              wr_en;
  logic              last;
  logic [DATA_W-1:0] scaled;

  always_comb begin
    dec_max = 3'd0;
    case (decim_q)
      2'd0: dec_max = 3'd0;
      2'd1: dec_max = 3'd1;
      2'd2: dec_max = 3'd3;
      default: dec_max = 3'd7;
    endcase
  end

  always_comb begin
    scaled = bus.data_input;
    case (scale_q)
      2'b00: scaled = bus.data_input;
      2'b01: scaled = bus.data_input[DATA_W-1] ? {DATA_W{1'b1}}
                                                : {bus.data_input[DATA_W-2:0], 1'b0};
      2'b10: scaled = {1'b0, bus.data_input[DATA_W-1:1]};
      default: scaled = {2'b00, bus.data_input[DATA_W-1:2]};
    endcase
  end

  // abort and reset both suppress the write that would otherwise land this cycle
  assign keep  = (dec_cnt_q == 3'd0);
  assign wr_en = (state_q == FILL) && bus.sample_valid && keep && !abort && !rst;
  assign last  = (wr_addr_q == ADDR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      scale_q    <= 2'b00;
      decim_q    <= 2'b00;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
      dec_cnt_q  <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= FILL;
            scale_q    <= scale;
            decim_q    <= decim;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
            dec_cnt_q  <= 3'd0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        FILL: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.sample_valid) begin
            dec_cnt_q <= (dec_cnt_q == dec_max) ? 3'd0 : dec_cnt_q + 3'd1;
            if (keep) begin
              wr_addr_q  <= wr_addr_q + ADDR_ONE;
              wr_count_q <= wr_count_q + CNT_ONE;
              if (last) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // no reset on the array so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr_q] <= scaled;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign bus.rd_data = rd_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_scale_capture_buffer.sv
// tb/tb_scale_capture_buffer.sv - directed bench for scale_capture_buffer with a frame-level model.
module tb_scale_capture_buffer;
  localparam int DW  = 12;
  localparam int DEP = 256;
  localparam int AW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    scale, decim;
  logic          start, abort;
  logic          busy, done;
  logic [AW:0]   wr_count;

  logic [1:0]    scale2, decim2;
  logic          start2, abort2;
  logic          busy2, done2;
  logic [4:0]    wr_count2;

  scale_capture_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  scale_capture_buffer_if #(.DATA_W(8), .ADDR_W(4))   bus2 ();

  scale_capture_buffer #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .bus(bus), .scale(scale), .decim(decim),
    .start(start), .abort(abort), .busy(busy), .done(done), .wr_count(wr_count)
  );

  scale_capture_buffer #(.DATA_W(8), .DEPTH(16)) dut_small (
    .clk(clk), .rst(rst), .bus(bus2), .scale(scale2), .decim(decim2),
    .start(start2), .abort(abort2), .busy(busy2), .done(done2), .wr_count(wr_count2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: an armed flag, a count of kept samples and an image of the stored frame.
  logic [DW-1:0] m_mem [DEP];
  bit            m_known [DEP];
  bit            m_armed = 0, m_done = 0, m_rd_known = 0, chk_en = 0;
  int            m_count = 0, m_vidx = 0, m_scale = 0, m_decim = 0;
  logic [DW-1:0] m_rd = '0;

  function automatic int gain(input int d, input int s);
    int v;
    case (s)
      0: v = d;
      1: v = (d * 2 > 4095) ? 4095 : d * 2;
      2: v = d / 2;
      default: v = d / 4;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_armed = 0; m_done = 0; m_count = 0; m_vidx = 0; m_rd = '0; m_rd_known = 1;
    end else begin
      m_rd_known = m_known[bus.rd_addr];
      m_rd       = m_mem[bus.rd_addr];
      if (m_armed) begin
        if (abort) begin
          m_armed = 0;
        end else if (bus.sample_valid) begin
          if (m_vidx % (1 << m_decim) == 0) begin
            m_mem[m_count]   = DW'(gain(int'(bus.data_input), m_scale));
            m_known[m_count] = 1;
            m_count++;
            if (m_count == DEP) begin
              m_armed = 0;
              m_done  = 1;
            end
          end
          m_vidx++;
        end
      end else if (start) begin
        m_armed = 1; m_done = 0; m_count = 0; m_vidx = 0;
        m_scale = int'(scale); m_decim = int'(decim);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_armed);
      check("done", done, m_done);
      check("wr_count", wr_count, m_count);
      if (m_rd_known) check("rd_data", bus.rd_data, m_rd);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic arm(input logic [1:0] s, input logic [1:0] dc);
    scale = s; decim = dc; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] d);
    bus.data_input = d; bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic rd(input int a, input int exp, input string name);
    bus.rd_addr = AW'(a);
    step();
    check(name, bus.rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; scale = 2'b00; decim = 2'b00; start = 1'b0; abort = 1'b0;
    bus.data_input = '0; bus.sample_valid = 1'b0; bus.rd_addr = '0;
    scale2 = 2'b00; decim2 = 2'b00; start2 = 1'b0; abort2 = 1'b0;
    bus2.data_input = '0; bus2.sample_valid = 1'b0; bus2.rd_addr = '0;
    step();
    chk_en = 1;
    step();
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wr_count", wr_count, 0);
    check("reset_rd_data", bus.rd_data, 0);

    // ramp x1, no decimation
    arm(2'b00, 2'b00);
    check("arm_busy", busy, 1);
    for (int i = 0; i < 256; i++) begin
      feed(DW'(i));
      if (i == 254) check("ramp_not_done_early", done, 0);
    end
    check("ramp_done", done, 1);
    check("ramp_busy", busy, 0);
    check("ramp_wr_count", wr_count, 256);
    for (int i = 0; i < 256; i++) rd(i, i, "ramp_readback");

    // gain x2 saturation and /4
    arm(2'b01, 2'b00);
    feed(12'h3FF); feed(12'h800); feed(12'hFFF);
    pulse_abort();
    check("gain_partial_count", wr_count, 3);
    rd(0, 'h7FE, "x2_3ff");
    rd(1, 'hFFF, "x2_800");
    rd(2, 'hFFF, "x2_fff");
    arm(2'b11, 2'b00);
    feed(12'hFFF);
    pulse_abort();
    rd(0, 'h3FF, "div4_fff");
    rd(1, 'hFFF, "partial_frame_kept");

    // decimation by 4 with valid gaps that must not shift the phase
    arm(2'b00, 2'b10);
    for (int i = 0; i < 1024; i++) begin
      feed(DW'(i));
      if (i == 1019) check("decim_not_done_early", done, 0);
      if (i == 1020) check("decim_done_at_last_kept", done, 1);
      if (i % 7 == 3) step();
    end
    check("decim_wr_count", wr_count, 256);
    rd(3, 12, "decim_mem3");
    rd(255, 1020, "decim_mem255");

    // abort after 100, then abort colliding with the final write
    arm(2'b00, 2'b00);
    for (int i = 0; i < 100; i++) feed(DW'(i + 500));
    pulse_abort();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wr_count", wr_count, 100);
    arm(2'b00, 2'b00);
    check("rearm_wr_count", wr_count, 0);
    for (int i = 0; i < 255; i++) feed(DW'(i + 7));
    abort = 1'b1;
    feed(12'hABC);
    abort = 1'b0;
    check("abort_final_done", done, 0);
    check("abort_final_count", wr_count, 255);
    rd(255, 1020, "abort_final_not_written");
    arm(2'b00, 2'b00);
    for (int i = 0; i < 256; i++) feed(DW'(3 * i));
    check("after_abort_frame_done", done, 1);

    // scale change and start while filling are both ignored
    arm(2'b00, 2'b00);
    for (int i = 0; i < 256; i++) begin
      if (i == 50) scale = 2'b10;
      if (i == 80) start = 1'b1;
      feed(DW'(i + 1000));
      start = 1'b0;
      if (i == 80) check("start_in_fill_count", wr_count, 81);
    end
    check("midfill_done", done, 1);
    rd(200, 1200, "midfill_scale_ignored");
    arm(2'b00, 2'b00);
    check("start_in_done_clears", done, 0);
    check("start_in_done_busy", busy, 1);
    abort = 1'b1; start = 1'b1;
    step();
    check("abort_wins_in_fill", busy, 0);
    step();
    check("start_wins_in_idle", busy, 1);
    abort = 1'b0; start = 1'b0;
    pulse_abort();

    // reset while filling
    arm(2'b00, 2'b00);
    for (int i = 0; i < 10; i++) feed(DW'(i + 2000));
    bus.rd_addr = AW'(10);
    rst = 1'b1; bus.data_input = 12'h555; bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_data", bus.rd_data, 0);
    rst = 1'b0;
    rd(10, 1010, "rst_blocks_write");

    // small build: 16 x 8-bit ramp
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("small_busy", busy2, 1);
    for (int i = 0; i < 16; i++) begin
      bus2.data_input = 8'(i + 240); bus2.sample_valid = 1'b1;
      step();
    end
    bus2.sample_valid = 1'b0;
    check("small_done", done2, 1);
    check("small_wr_count", wr_count2, 16);
    for (int i = 0; i < 16; i++) begin
      bus2.rd_addr = 4'(i);
      step();
      check("small_readback", bus2.rd_data, i + 240);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
